datamem_lsu: RTL
================

DATAMEM_LSU -- requirements
Module: datamem_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning the byte-address width (2^ADDR_W bytes of storage).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the memory word width; legal values are 32 and 64.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning the request-to-response latency in cycles; legal values are 1 and 2.
REQ-004 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  request present this cycle.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_funct3  in  3  RISC-V funct3 giving access size and signedness.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  DATA_W  store data, right-aligned.
REQ-013 rsp_valid  out  1  response for the request accepted RD_LAT cycles earlier.
REQ-014 rsp_rdata  out  DATA_W  load result, sign- or zero-extended.
REQ-015 rsp_fault  out  1  the request was misaligned or had an illegal funct3.
REQ-016 fault_cnt  out  16  saturating count of faulted requests.

Function
REQ-017 Storage SHALL be 2^ADDR_W/(DATA_W/8) words; word index = req_addr[ADDR_W-1:log2(DATA_W/8)]; byte lane = remaining low bits.
REQ-018 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_ready SHALL be 1 in every cycle except while reset is high.
REQ-019 Load funct3 SHALL be decoded as follows: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and when DATA_W=64 also 011 LD and 110 LWU.
REQ-020 Store funct3 SHALL be decoded as follows: 000 SB, 001 SH, 010 SW, and when DATA_W=64 also 011 SD.
REQ-021 Any other funct3 SHALL fault.
REQ-022 Alignment: halfword SHALL require addr[0]=0; word SHALL require addr[1:0]=0; doubleword SHALL require addr[2:0]=0; a violation SHALL fault.
REQ-023 An accepted store SHALL write only the addressed byte lanes, through a per-byte write enable, at the accepting edge; all other bytes of the word SHALL be unchanged.
REQ-024 A faulted store SHALL write nothing.
REQ-025 An accepted load SHALL read the word, shift the addressed lanes to bit 0, and sign-extend (LB/LH/LW on 64) or zero-extend (LBU/LHU/LWU) to DATA_W.
REQ-026 rsp_valid SHALL assert exactly RD_LAT cycles after acceptance, for exactly one cycle per accepted request, for both loads and stores; rsp_rdata SHALL be 0 for stores.
REQ-027 On fault, rsp_fault SHALL be 1 and rsp_rdata SHALL be 0; rsp_fault SHALL be 0 whenever rsp_valid is 0.
REQ-028 Back-to-back requests SHALL be accepted every cycle; the response pipeline SHALL hold RD_LAT requests in flight, and responses SHALL return in order.
REQ-029 A load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-030 A load and store to the same word on one edge cannot occur (single port).
REQ-031 fault_cnt SHALL increment by 1 on each faulted acceptance and saturate at 16'hFFFF.
REQ-032 rsp_rdata and rsp_fault SHALL be registered outputs with no combinational path from req_* to rsp_*.
REQ-033 Out-of-range parameter values SHALL stop elaboration with $fatal.

Reset
REQ-034 While reset is high: req_ready=0, rsp_valid=0, rsp_fault=0, rsp_rdata=0, fault_cnt=0, and all in-flight pipeline stages SHALL be cleared.
REQ-035 Reset asserted mid-operation SHALL drop in-flight responses; no rsp_valid SHALL appear for requests accepted before reset.
REQ-036 Memory contents SHALL NOT be cleared by reset; stores committed before reset SHALL persist.
REQ-037 req_ready SHALL return to 1 in the first cycle after reset deasserts.

Verification
REQ-038 DATA_W=32, RD_LAT=1: SW 0x8000_00F1 to addr 0x10, then LB 0x10 -> rsp_rdata=0xFFFF_FFF1; LBU 0x10 -> 0x0000_00F1; LH 0x12 -> 0xFFFF_8000.
REQ-039 SW 0x1122_3344 to addr 0x20, then SB 0xAA to addr 0x21, then LW 0x20 -> 0x1122_AA44, proving per-byte lanes.
REQ-040 LW addr 0x22 and SH addr 0x23 -> rsp_fault=1, rsp_rdata=0, memory unchanged, fault_cnt=2; funct3=111 -> fault, fault_cnt=3.
REQ-041 RD_LAT=2: issue four loads on consecutive cycles -> four rsp_valid pulses in issue order, each 2 cycles after its acceptance.
REQ-042 DATA_W=64: SD 0x8000_0000_0000_0001 to addr 0x8, then LW 0xC -> 0xFFFF_FFFF_8000_0000; LWU 0xC -> 0x0000_0000_8000_0000.
REQ-043 Accept a load, assert reset on the next edge -> no rsp_valid; after reset the earlier stored data SHALL still be readable; force 65536 faults -> fault_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/datamem_lsu.sv
// Byte-addressable data memory with a RISC-V style load/store unit front end.
// Requests are accepted every cycle outside reset; responses return in order
// after a fixed RD_LAT-cycle pipeline, carrying load data or a fault flag.
module datamem_lsu #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [15:0]       fault_cnt
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(NBYTES);
    localparam int unsigned WIDX_W = ADDR_W - LANE_W;
    localparam int unsigned DEPTH  = 2 ** WIDX_W;
    localparam bit          IS64   = (DATA_W == 64);

    // Reject parameter values the datapath was not built for
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $fatal(1, "datamem_lsu: DATA_W must be 32 or 64");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $fatal(1, "datamem_lsu: RD_LAT must be 1 or 2");
    end
    if (ADDR_W < 4 || ADDR_W > 24) begin : g_bad_addr_w
        $fatal(1, "datamem_lsu: ADDR_W must be in 4..24");
    end

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    logic                     w_accept;
    logic [WIDX_W-1:0]        w_widx;
    logic [LANE_W-1:0]        w_lane;
    logic [LANE_W+2:0]        w_bit_off;
    size_e                    w_size;
    logic                     w_uns;
    logic                     w_f3_ok;
    logic                     w_misal;
    logic                     w_fault;
    logic [NBYTES-1:0]        w_be_base;
    logic [NBYTES-1:0]        w_be;
    logic [DATA_W-1:0]        w_wdata_sh;
    logic [DATA_W-1:0]        w_word;
    logic [DATA_W-1:0]        w_word_sh;
    logic [6:0]               w_ext_sh;
    logic [DATA_W-1:0]        w_ext_l;
    logic signed [DATA_W-1:0] w_load_s;
    logic [DATA_W-1:0]        w_load;
    logic [DATA_W-1:0]        w_rsp_data;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [RD_LAT-1:0]        r_vld;
    logic [RD_LAT-1:0]        r_flt;
    logic [DATA_W-1:0]        r_dat [RD_LAT];
    logic [15:0]              r_fault_cnt;

    // Single port, no backpressure: ready whenever reset is not asserted
    assign req_ready = ~reset;
    assign w_accept  = req_valid & ~reset;
    assign w_widx    = req_addr[ADDR_W-1:LANE_W];
    assign w_lane    = req_addr[LANE_W-1:0];
    assign w_bit_off = {w_lane, 3'b000};

    // funct3 decode into access size, signedness and legality
    always_comb begin
        w_size  = SZ_B;
        w_uns   = 1'b0;
        w_f3_ok = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  begin w_size = SZ_B; w_f3_ok = 1'b1; end
                3'b001:  begin w_size = SZ_H; w_f3_ok = 1'b1; end
                3'b010:  begin w_size = SZ_W; w_f3_ok = 1'b1; end
                3'b011:  begin w_size = SZ_D; w_f3_ok = IS64; end
                default: w_f3_ok = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000:  begin w_size = SZ_B; w_f3_ok = 1'b1; end
                3'b001:  begin w_size = SZ_H; w_f3_ok = 1'b1; end
                3'b010:  begin w_size = SZ_W; w_f3_ok = 1'b1; end
                3'b011:  begin w_size = SZ_D; w_f3_ok = IS64; end
                3'b100:  begin w_size = SZ_B; w_uns = 1'b1; w_f3_ok = 1'b1; end
                3'b101:  begin w_size = SZ_H; w_uns = 1'b1; w_f3_ok = 1'b1; end
                3'b110:  begin w_size = SZ_W; w_uns = 1'b1; w_f3_ok = IS64; end
                default: w_f3_ok = 1'b0;
            endcase
        end
    end

    // Natural alignment check and per-size lane mask / extension shift
    always_comb begin
        w_misal   = 1'b0;
        w_be_base = NBYTES'(1);
        w_ext_sh  = 7'(DATA_W - 8);
        case (w_size)
            SZ_B: begin
                w_misal   = 1'b0;
                w_be_base = NBYTES'(1);
                w_ext_sh  = 7'(DATA_W - 8);
            end
            SZ_H: begin
                w_misal   = req_addr[0];
                w_be_base = NBYTES'(3);
                w_ext_sh  = 7'(DATA_W - 16);
            end
            SZ_W: begin
                w_misal   = |req_addr[1:0];
                w_be_base = NBYTES'(15);
                w_ext_sh  = 7'(DATA_W - 32);
            end
            default: begin
                w_misal   = |req_addr[2:0];
                w_be_base = {NBYTES{1'b1}};
                w_ext_sh  = 7'd0;
            end
        endcase
    end

    assign w_fault    = ~w_f3_ok | w_misal;
    assign w_be       = w_be_base << w_lane;
    assign w_wdata_sh = req_wdata << w_bit_off;

    // Load path: bring addressed lanes to bit 0, then sign/zero extend
    assign w_word     = r_mem[w_widx];
    assign w_word_sh  = w_word >> w_bit_off;
    assign w_ext_l    = w_word_sh << w_ext_sh;
    assign w_load_s   = $signed(w_ext_l) >>> w_ext_sh;
    assign w_load     = w_uns ? (w_ext_l >> w_ext_sh) : $unsigned(w_load_s);
    assign w_rsp_data = (!req_we && !w_fault) ? w_load : '0;

    // Byte-lane store; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_fault) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_widx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the result at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_flt <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            r_flt[0] <= w_accept & w_fault;
            r_dat[0] <= w_accept ? w_rsp_data : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_flt[i] <= r_flt[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    // Saturating count of faulted acceptances
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_cnt <= '0;
        end else if (w_accept && w_fault && (r_fault_cnt != 16'hFFFF)) begin
            r_fault_cnt <= r_fault_cnt + 16'd1;
        end
    end

    // Reset masks the registered outputs at once so an in-flight
    // response never surfaces once reset has been raised
    assign rsp_valid = r_vld[RD_LAT-1] & ~reset;
    assign rsp_fault = r_flt[RD_LAT-1] & ~reset;
    assign rsp_rdata = reset ? '0 : r_dat[RD_LAT-1];
    assign fault_cnt = reset ? '0 : r_fault_cnt;

endmodule
